keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_scanner.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad-side pins and key-report outputs of the keypad scanner.
// The master modport is the scanner; the slave modport is the board/consumer side.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce; optional auto-repeat under KEY_REPEAT_EN.
// Latency: key_valid pulses 1 clock after the scan that completes debounce.
// Backpressure: none; the scan never stalls and key_valid is a fire-and-forget strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_RATE    = 8
) (
    input  logic             clock,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int            SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    DS        = 4'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    col;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic [2:0]    col_n;
    logic [1:0]    col_row;
    logic [2:0]    hit_sum;
    logic [1:0]    tot_hits;
    logic [3:0]    tot_code;
    logic          slot_last, scan_done, res_none, res_single;
    state_t        state;
    logic [3:0]    cnt, cnt_inc, cand;
    logic [3:0]    key_reg;
    logic          key_valid_reg, key_held_reg;
`ifdef KEY_REPEAT_EN
    logic [15:0]   rpt_cnt, rpt_next, rpt_limit;
    logic          rpt_fast;
`endif

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'd0;
        case ({r, c})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  4'hF: code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign scan_done  = slot_last && (col == 2'd3);
    assign res_none   = (tot_hits == 2'd0);
    assign res_single = (tot_hits == 2'd1);
    assign cnt_inc    = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;

    // Fold this column's rows into the running scan result; hit count saturates at 2 (MULTI).
    always_comb begin
        col_n   = 3'd0;
        col_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2[r]) begin
                col_n   = col_n + 3'd1;
                col_row = 2'(r);
            end
        end
        hit_sum  = {1'b0, acc_hits} + col_n;
        tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_code = (acc_hits == 2'd1) ? acc_code : key_code(col_row, col);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_s1   <= 4'b1111;
            row_s2   <= 4'b1111;
            slot_cnt <= '0;
            col      <= 2'd0;
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            row_s1 <= kp.row_in;
            row_s2 <= row_s1;
            if (slot_last) begin
                slot_cnt <= '0;
                col      <= col + 2'd1;
                acc_hits <= (col == 2'd3) ? 2'd0 : tot_hits;
                acc_code <= (col == 2'd3) ? 4'd0 : tot_code;
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

`ifdef KEY_REPEAT_EN
    assign rpt_next  = rpt_cnt + 16'd1;
    assign rpt_limit = rpt_fast ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            cand          <= 4'd0;
            key_reg       <= 4'd0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt       <= 16'd0;
            rpt_fast      <= 1'b0;
`endif
        end else begin
            key_valid_reg <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (res_single) begin
                            cand <= tot_code;
                            if (DS <= 4'd1) begin
                                state         <= PRESSED;
                                key_reg       <= tot_code;
                                key_valid_reg <= 1'b1;
                                key_held_reg  <= 1'b1;
                                cnt           <= 4'd0;
`ifdef KEY_REPEAT_EN
                                rpt_cnt       <= 16'd0;
                                rpt_fast      <= 1'b0;
`endif
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (res_single && tot_code == cand) begin
                            if (cnt_inc >= DS) begin
                                state         <= PRESSED;
                                key_reg       <= cand;
                                key_valid_reg <= 1'b1;
                                key_held_reg  <= 1'b1;
                                cnt           <= 4'd0;
`ifdef KEY_REPEAT_EN
                                rpt_cnt       <= 16'd0;
                                rpt_fast      <= 1'b0;
`endif
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end
                    end
                    PRESSED: begin
                        // Any key activity keeps the press alive; rollover never re-strobes.
                        if (res_none) begin
`ifdef KEY_REPEAT_EN
                            rpt_cnt  <= 16'd0;
                            rpt_fast <= 1'b0;
`endif
                            if (DS <= 4'd1) begin
                                state        <= IDLE;
                                key_held_reg <= 1'b0;
                                cnt          <= 4'd0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= 4'd1;
                            end
                        end
`ifdef KEY_REPEAT_EN
                        else if (res_single) begin
                            if (rpt_next >= rpt_limit) begin
                                key_valid_reg <= 1'b1;
                                rpt_cnt       <= 16'd0;
                                rpt_fast      <= 1'b1;
                            end else begin
                                rpt_cnt <= rpt_next;
                            end
                        end
`endif
                    end
                    RELEASE: begin
                        if (res_none) begin
                            if (cnt_inc >= DS) begin
                                state        <= IDLE;
                                key_held_reg <= 1'b0;
                                cnt          <= 4'd0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= PRESSED;
                            cnt   <= 4'd0;
`ifdef KEY_REPEAT_EN
                            rpt_cnt  <= 16'd0;
                            rpt_fast <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.col_out   = ~(4'b0001 << col);
    assign kp.key       = key_reg;
    assign kp.key_valid = key_valid_reg;
    assign kp.key_held  = key_held_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: SCAN_DIV=4, DEBOUNCE_SCANS=3, 16-cycle scans.
// A matrix model drives rows from col_out; scan boundaries are found from the 0111->1110 column wrap.
module tb_keypad_scanner;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(3),
        .REPEAT_DELAY(4),
        .REPEAT_RATE(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp(kp)
    );

    logic [15:0] pressed = 16'd0;
    int checks    = 0;
    int fails     = 0;
    int pulse_cnt = 0;

    always_comb begin
        logic [3:0] rows;
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
        kp.row_in = rows;
    end

    always @(negedge clock) if (kp.key_valid === 1'b1) pulse_cnt++;

    function automatic int idx(input int r, input int c);
        return r * 4 + c;
    endfunction

    task automatic wait_scan_end();
        logic [3:0] prev;
        bit seen;
        prev = kp.col_out;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (prev == 4'b0111 && kp.col_out == 4'b1110) seen = 1'b1;
            prev = kp.col_out;
        end
        if (!seen) begin
            checks++; fails++;
            $display("FAIL scan_timeout col_out=%b required a 0111->1110 wrap", kp.col_out);
        end
    endtask

    task automatic run_scans(input int n, output logic [15:0] vm);
        vm = 16'd0;
        for (int s = 0; s < n; s++) begin
            wait_scan_end();
            vm[s] = kp.key_valid;
        end
    endtask

    task automatic release_all();
        logic [15:0] vm;
        pressed = 16'd0;
        run_scans(4, vm);
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (kp.col_out !== 4'b1110) begin fails++; $display("FAIL rst_col col_out=%b required 1110", kp.col_out); end
        checks++; if (kp.key !== 4'd0) begin fails++; $display("FAIL rst_key key=%0d required 0", kp.key); end
        checks++; if (kp.key_valid !== 1'b0) begin fails++; $display("FAIL rst_valid key_valid=%b required 0", kp.key_valid); end
        checks++; if (kp.key_held !== 1'b0) begin fails++; $display("FAIL rst_held key_held=%b required 0", kp.key_held); end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = 4'b1111 ^ (4'b0001 << (k / 4));
            checks++;
            if (kp.col_out !== exp) begin fails++; $display("FAIL col_rot k=%0d col_out=%b required %b", k, kp.col_out, exp); end
            @(negedge clock);
        end
    endtask

    task automatic test_accept();
        logic [15:0] vm;
        int p0;
        wait_scan_end();
        p0 = pulse_cnt;
        pressed[idx(1,1)] = 1'b1;
        run_scans(5, vm);
        checks++; if (vm[4:0] !== 5'b00100) begin fails++; $display("FAIL accept_timing pulses=%b required 00100", vm[4:0]); end
        checks++; if (kp.key !== 4'd5) begin fails++; $display("FAIL accept_key key=%0d required 5", kp.key); end
        checks++; if (kp.key_held !== 1'b1) begin fails++; $display("FAIL accept_held key_held=%b required 1", kp.key_held); end
        checks++; if (pulse_cnt - p0 != 1) begin fails++; $display("FAIL accept_count pulses=%0d required 1", pulse_cnt - p0); end
        release_all();
        checks++; if (kp.key_held !== 1'b0) begin fails++; $display("FAIL release_held key_held=%b required 0", kp.key_held); end
        checks++; if (kp.key !== 4'd5) begin fails++; $display("FAIL release_key key=%0d required 5", kp.key); end
    endtask

    task automatic test_bounce();
        logic [15:0] vm;
        int p0;
        p0 = pulse_cnt;
        pressed[idx(2,1)] = 1'b1;
        run_scans(2, vm);
        pressed = 16'd0;
        run_scans(3, vm);
        checks++; if (pulse_cnt - p0 != 0) begin fails++; $display("FAIL short_press pulses=%0d required 0", pulse_cnt - p0); end
        checks++; if (kp.key_held !== 1'b0) begin fails++; $display("FAIL short_held key_held=%b required 0", kp.key_held); end
        pressed[idx(2,1)] = 1'b1;
        run_scans(1, vm);
        pressed = 16'd0;
        pressed[idx(2,0)] = 1'b1;
        run_scans(4, vm);
        checks++; if (vm[3:0] !== 4'b1000) begin fails++; $display("FAIL switch_timing pulses=%b required 1000", vm[3:0]); end
        checks++; if (kp.key !== 4'd7) begin fails++; $display("FAIL switch_key key=%0d required 7", kp.key); end
        release_all();
    endtask

    task automatic test_multi();
        logic [15:0] vm;
        int p0;
        p0 = pulse_cnt;
        pressed[idx(0,0)] = 1'b1;
        pressed[idx(0,2)] = 1'b1;
        run_scans(4, vm);
        checks++; if (pulse_cnt - p0 != 0) begin fails++; $display("FAIL multi_idle pulses=%0d required 0", pulse_cnt - p0); end
        checks++; if (kp.key !== 4'd7) begin fails++; $display("FAIL multi_key key=%0d required 7", kp.key); end
        release_all();
        pressed[idx(2,2)] = 1'b1;
        run_scans(4, vm);
        checks++; if (vm[3:0] !== 4'b0100) begin fails++; $display("FAIL key9_timing pulses=%b required 0100", vm[3:0]); end
        p0 = pulse_cnt;
        pressed[idx(3,1)] = 1'b1;
        run_scans(4, vm);
        checks++; if (pulse_cnt - p0 != 0) begin fails++; $display("FAIL rollover pulses=%0d required 0", pulse_cnt - p0); end
        checks++; if (kp.key !== 4'd9) begin fails++; $display("FAIL rollover_key key=%0d required 9", kp.key); end
        checks++; if (kp.key_held !== 1'b1) begin fails++; $display("FAIL rollover_held key_held=%b required 1", kp.key_held); end
        release_all();
    endtask

    task automatic test_release_bounce();
        logic [15:0] vm;
        int p0;
        pressed[idx(3,1)] = 1'b1;
        run_scans(4, vm);
        checks++; if (kp.key !== 4'd0) begin fails++; $display("FAIL key0 key=%0d required 0", kp.key); end
        p0 = pulse_cnt;
        pressed = 16'd0;
        run_scans(2, vm);
        checks++; if (kp.key_held !== 1'b1) begin fails++; $display("FAIL rel2_held key_held=%b required 1", kp.key_held); end
        pressed[idx(3,1)] = 1'b1;
        run_scans(2, vm);
        checks++; if (pulse_cnt - p0 != 0) begin fails++; $display("FAIL repress pulses=%0d required 0", pulse_cnt - p0); end
        checks++; if (kp.key_held !== 1'b1) begin fails++; $display("FAIL repress_held key_held=%b required 1", kp.key_held); end
        pressed = 16'd0;
        run_scans(3, vm);
        checks++; if (kp.key_held !== 1'b0) begin fails++; $display("FAIL rel3_held key_held=%b required 0", kp.key_held); end
        checks++; if (kp.key !== 4'd0) begin fails++; $display("FAIL rel3_key key=%0d required 0", kp.key); end
        pressed[idx(3,2)] = 1'b1;
        run_scans(4, vm);
        checks++; if (vm[3:0] !== 4'b0100) begin fails++; $display("FAIL hash_timing pulses=%b required 0100", vm[3:0]); end
        checks++; if (kp.key !== 4'd15) begin fails++; $display("FAIL hash_key key=%0d required 15", kp.key); end
        release_all();
    endtask

    task automatic test_repeat();
        logic [15:0] vm;
        logic [9:0]  exp;
`ifdef KEY_REPEAT_EN
        exp = 10'b01_0100_0100;
`else
        exp = 10'b00_0000_0100;
`endif
        pressed[idx(0,1)] = 1'b1;
        run_scans(10, vm);
        checks++; if (vm[9:0] !== exp) begin fails++; $display("FAIL repeat_pulses got=%b required %b", vm[9:0], exp); end
        checks++; if (kp.key !== 4'd2) begin fails++; $display("FAIL repeat_key key=%0d required 2", kp.key); end
        release_all();
    endtask

    task automatic test_reset_mid();
        logic [15:0] vm;
        pressed[idx(1,1)] = 1'b1;
        run_scans(4, vm);
        checks++; if (kp.key !== 4'd5) begin fails++; $display("FAIL pre_rst_key key=%0d required 5", kp.key); end
        repeat (5) @(negedge clock);
        #3 reset = 1'b1;
        #1;
        checks++; if (kp.col_out !== 4'b1110) begin fails++; $display("FAIL mid_rst_col col_out=%b required 1110", kp.col_out); end
        checks++; if (kp.key !== 4'd0) begin fails++; $display("FAIL mid_rst_key key=%0d required 0", kp.key); end
        checks++; if (kp.key_held !== 1'b0) begin fails++; $display("FAIL mid_rst_held key_held=%b required 0", kp.key_held); end
        @(negedge clock);
        pressed = 16'd0;
        reset   = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_accept();
        test_bounce();
        test_multi();
        test_release_bounce();
        test_repeat();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
